lif_layer: RTL and testbench
============================

LIF_LAYER -- requirements
Module: lif_layer

Interface
REQ-001 Parameter WIDTH, 16, potential width in bits, unsigned fixed point with scale 2^WIDTH.
REQ-002 Parameter NUM_NEURONS, 8, neuron count; legal range 1..256.
REQ-003 Parameter LAMBDA, 32768, decay factor in units of 2^-WIDTH (32768 = 0.5 at WIDTH 16).
REQ-004 Parameter WEIGHT, 32768, potential increment added when a neuron's input bit is 1.
REQ-005 Parameter THRESHOLD, 49152, spike threshold; compared as an unsigned WIDTH+1-bit value.
REQ-006 Parameter REFRACTORY, 2, timesteps a neuron is held after a spike; 0 disables the hold; legal range 0..15.
REQ-007 clk  input  1  single clock; all state updates on its rising edge.
REQ-008 rst_n  input  1  reset, synchronous and active-low.
REQ-009 in_valid  input  1  a timestep input vector is present.
REQ-010 in_ready  output  1  the block can accept a timestep.
REQ-011 in_bits  input  NUM_NEURONS  binary input per neuron; bit i drives neuron i.
REQ-012 out_valid  output  1  spike vector for the completed timestep is valid.
REQ-013 out_ready  input  1  consumer accepts the spike vector.
REQ-014 spikes  output  NUM_NEURONS  spike flags of the completed timestep.
REQ-015 pot_sel  input  clog2(NUM_NEURONS), minimum 1  neuron index for the debug read.
REQ-016 pot_out  output  WIDTH  combinational read of potential[pot_sel]; 0 if pot_sel >= NUM_NEURONS.

Function
REQ-017 FSM states: IDLE, UPDATE, DONE.
REQ-018 IDLE: in_ready = 1; when in_valid is 1, in_bits is captured, idx is cleared to 0, and the FSM enters UPDATE.
REQ-019 UPDATE: in_ready = 0; one neuron (idx) is updated per cycle; after idx = NUM_NEURONS-1 the FSM enters DONE.
REQ-020 DONE: out_valid = 1, and spikes holds stable until out_ready = 1; then the FSM returns to IDLE.
REQ-021 Latency: out_valid rises NUM_NEURONS+1 cycles after the accepting edge; throughput is one timestep per NUM_NEURONS+2 cycles when out_ready is held at 1.
REQ-022 Decay: d = (V * LAMBDA) >> WIDTH, computed with a 2*WIDTH-bit product and truncated.
REQ-023 Sum: s = d + (bit ? WEIGHT : 0), computed at WIDTH+1 bits.
REQ-024 If s >= THRESHOLD: spikes[idx] = 1, V becomes 0, and refr[idx] is loaded with REFRACTORY.
REQ-025 If s < THRESHOLD: spikes[idx] = 0, and V becomes s saturated to 2^WIDTH-1; it never wraps.
REQ-026 If refr[idx] != 0: the input bit is ignored, V is forced to 0, spikes[idx] = 0, and refr[idx] decrements by 1.
REQ-027 Each timestep's spikes vector is cleared on entry to UPDATE, so no stale bits remain.
REQ-028 in_bits changing during UPDATE or DONE has no effect.
REQ-029 in_valid arriving in DONE is not accepted until the cycle after the FSM returns to IDLE.

Reset
REQ-030 When rst_n = 0 at a clock edge, the following are cleared: state = IDLE, idx = 0, all potentials = 0, all refr = 0, spikes = 0, out_valid = 0.
REQ-031 A reset asserted mid-UPDATE or mid-DONE discards the timestep; no out_valid is produced for it.
REQ-032 in_ready reads 0 while rst_n = 0 and reads 1 in the first cycle after release.

Structure
REQ-033 Shared package lif_pkg holds the state enum type and the refractory counter width constant (4).
REQ-034 Sub-module lif_update holds the single-neuron datapath (decay, add, saturate, compare, refractory logic); it is instantiated once and time-multiplexed.
REQ-035 Potentials and refractory counters are held in register arrays indexed by idx; no RAM macro is used.

Verification
REQ-036 Parameters: defaults with NUM_NEURONS = 4; neuron 0 receives bit = 1 every step -> potentials 32768, then spike with V = 0, then 0 and 0 during refractory, then 32768, then spike.
REQ-037 All bits = 0 with V = 40000 -> V goes 20000, 10000, 5000, with no spikes.
REQ-038 Saturation test with WEIGHT = 65535, LAMBDA = 65535, THRESHOLD = 131071 and bit = 1 -> V saturates at 65535 and never wraps, with no spike.
REQ-039 out_ready held at 0 for 5 cycles in DONE -> spikes and out_valid remain stable, in_ready = 0, and a new in_valid is not accepted.
REQ-040 rst_n pulsed low during UPDATE at idx = 2 -> next cycle state = IDLE, all potentials = 0, and no out_valid.
REQ-041 Latency check -> out_valid rises exactly 5 cycles after acceptance with NUM_NEURONS = 4.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared types and constants for the leaky integrate-and-fire layer.
package lif_pkg;

    localparam int REFR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DONE   = 2'd2
    } lif_state_e;

    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lif_update.sv
// Single-neuron LIF datapath: decay, integrate, saturate, fire, refractory.
module lif_update
    import lif_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int LAMBDA     = 32768,
    parameter int WEIGHT     = 32768,
    parameter int THRESHOLD  = 49152,
    parameter int REFRACTORY = 2
) (
    input  logic [WIDTH-1:0]  v_i,
    input  logic [REFR_W-1:0] refr_i,
    input  logic              bit_i,
    output logic [WIDTH-1:0]  v_o,
    output logic [REFR_W-1:0] refr_o,
    output logic              spike_o
);

    localparam logic [WIDTH-1:0]  LAM  = WIDTH'(LAMBDA);
    localparam logic [WIDTH:0]    WGT  = (WIDTH+1)'(WEIGHT);
    localparam logic [WIDTH:0]    THR  = (WIDTH+1)'(THRESHOLD);
    localparam logic [REFR_W-1:0] REFR = REFR_W'(REFRACTORY);

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   dec;
    logic [WIDTH:0]     sum;

    always_comb begin
        prod    = {{WIDTH{1'b0}}, v_i} * {{WIDTH{1'b0}}, LAM};
        dec     = WIDTH'(prod >> WIDTH);
        sum     = {1'b0, dec} + (bit_i ? WGT : '0);
        v_o     = '0;
        refr_o  = '0;
        spike_o = 1'b0;
        // A held neuron stays silent at zero regardless of its input.
        if (refr_i != '0) begin
            refr_o = refr_i - REFR_W'(1);
        end else if (sum >= THR) begin
            spike_o = 1'b1;
            refr_o  = REFR;
        end else begin
            v_o = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/lif_layer.sv
// LIF neuron layer: one shared update datapath walks all neurons per timestep.
module lif_layer
    import lif_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int NUM_NEURONS = 8,
    parameter int LAMBDA      = 32768,
    parameter int WEIGHT      = 32768,
    parameter int THRESHOLD   = 49152,
    parameter int REFRACTORY  = 2,
    localparam int SEL_W      = sel_w(NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_NEURONS-1:0] in_bits,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_NEURONS-1:0] spikes,
    input  logic [SEL_W-1:0]       pot_sel,
    output logic [WIDTH-1:0]       pot_out
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_NEURONS - 1);

    lif_state_e             state_q, state_d;
    logic [SEL_W-1:0]       idx_q, idx_d;
    logic [NUM_NEURONS-1:0] bits_q, bits_d;
    logic [NUM_NEURONS-1:0] spk_q, spk_d;
    logic [WIDTH-1:0]       pot_q  [NUM_NEURONS];
    logic [REFR_W-1:0]      refr_q [NUM_NEURONS];

    logic [WIDTH-1:0]  v_nxt;
    logic [REFR_W-1:0] r_nxt;
    logic              spk_nxt;

    lif_update #(
        .WIDTH      (WIDTH),
        .LAMBDA     (LAMBDA),
        .WEIGHT     (WEIGHT),
        .THRESHOLD  (THRESHOLD),
        .REFRACTORY (REFRACTORY)
    ) u_update (
        .v_i     (pot_q[idx_q]),
        .refr_i  (refr_q[idx_q]),
        .bit_i   (bits_q[idx_q]),
        .v_o     (v_nxt),
        .refr_o  (r_nxt),
        .spike_o (spk_nxt)
    );

    assign in_ready  = rst_n && (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign spikes    = spk_q;
    assign pot_out   = (int'(pot_sel) < NUM_NEURONS) ? pot_q[pot_sel] : '0;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bits_d  = bits_q;
        spk_d   = spk_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    bits_d  = in_bits;
                    idx_d   = '0;
                    spk_d   = '0;
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                spk_d[idx_q] = spk_nxt;
                idx_d        = idx_q + SEL_W'(1);
                if (idx_q == LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            bits_q  <= '0;
            spk_q   <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                pot_q[i]  <= '0;
                refr_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bits_q  <= bits_d;
            spk_q   <= spk_d;
            if (state_q == ST_UPDATE) begin
                pot_q[idx_q]  <= v_nxt;
                refr_q[idx_q] <= r_nxt;
            end
        end
    end

endmodule

// File: tb/tb_lif_layer.sv
// Scoreboard bench for lif_layer with a timestep-level neuron reference model.
module tb_lif_layer;

    localparam int N     = 4;
    localparam int W     = 16;
    localparam int LAM   = 32768;
    localparam int WGT   = 32768;
    localparam int THR   = 49152;
    localparam int REFR  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [N-1:0] in_bits, spikes;
    logic [1:0]   pot_sel;
    logic [W-1:0] pot_out;

    logic         s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [N-1:0] s_in_bits, s_spikes;
    logic [1:0]   s_pot_sel;
    logic [W-1:0] s_pot_out;

    lif_layer #(.NUM_NEURONS(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
        .out_valid(out_valid), .out_ready(out_ready), .spikes(spikes),
        .pot_sel(pot_sel), .pot_out(pot_out)
    );

    lif_layer #(
        .NUM_NEURONS(N), .LAMBDA(65535), .WEIGHT(65535), .THRESHOLD(131071)
    ) u_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_bits(s_in_bits),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .spikes(s_spikes),
        .pot_sel(s_pot_sel), .pot_out(s_pot_out)
    );

    typedef struct {
        logic [N-1:0] sp;
        int           pot [N];
        int           acc;
    } exp_t;

    exp_t q[$];
    int   mv [N];
    int   mr [N];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   sat_n = 0;
    int   dir_k = 0;
    bit   dir_mode = 1'b0;
    bit   rnd_mode = 1'b0;
    bit   fresh = 1'b1;
    int   dir_pot [6] = '{32768, 0, 0, 0, 32768, 0};
    int   dir_spk [6] = '{0, 1, 0, 0, 0, 1};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            mv[i] = 0;
            mr[i] = 0;
        end
    endfunction

    // One timestep of every neuron, straight from the behavioural rules.
    function automatic exp_t model_step(input logic [N-1:0] b);
        exp_t  e;
        longint d, s;
        for (int i = 0; i < N; i++) begin
            e.sp[i] = 1'b0;
            if (mr[i] > 0) begin
                mv[i] = 0;
                mr[i] = mr[i] - 1;
            end else begin
                d = (longint'(mv[i]) * LAM) / 65536;
                s = d + (b[i] ? WGT : 0);
                if (s >= THR) begin
                    e.sp[i] = 1'b1;
                    mv[i] = 0;
                    mr[i] = REFR;
                end else begin
                    mv[i] = (s > 65535) ? 65535 : int'(s);
                end
            end
            e.pot[i] = mv[i];
        end
        e.acc = 0;
        return e;
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_out_valid", int'(out_valid), 0);
            end else begin
                if (fresh) begin
                    check("latency", cyc - q[0].acc, N + 1);
                    fresh = 1'b0;
                end
                check("spikes", int'(spikes), int'(q[0].sp));
                check("pot_done", int'(pot_out), q[0].pot[pot_sel]);
                check("in_ready_done", int'(in_ready), 0);
                if (out_ready) begin
                    if (dir_mode && dir_k < 6) begin
                        check("dir_pot0", int'(pot_out), dir_pot[dir_k]);
                        check("dir_spk0", int'(spikes[0]), dir_spk[dir_k]);
                        dir_k++;
                    end
                    void'(q.pop_front());
                    fresh = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && s_out_valid) begin
            check("sat_pot", int'(s_pot_out), 65535);
            check("sat_spikes", int'(s_spikes), 0);
            check("sat_in_ready", int'(s_in_ready), 0);
            sat_n++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_mode) begin
                out_ready = ($urandom % 4) == 0;
                pot_sel   = 2'($urandom);
            end
        end
    end

    task automatic issue(input logic [N-1:0] b, input bit track);
        exp_t e;
        int   t = 0;
        in_valid = 1'b1;
        in_bits  = b;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("accept_timeout", int'(in_ready), 1);
        end else if (track) begin
            e = model_step(b);
            e.acc = cyc;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_bits  = N'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_bits = '0;
        out_ready = 1'b0;
        pot_sel = '0;
        s_in_valid = 1'b1;
        s_in_bits = '1;
        s_out_ready = 1'b1;
        s_pot_sel = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("in_ready_in_reset", int'(in_ready), 0);
        check("out_valid_in_reset", int'(out_valid), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_release", int'(in_ready), 1);
        for (int i = 0; i < N; i++) begin
            pot_sel = 2'(i);
            #1;
            check("pot_reset", int'(pot_out), 0);
        end
        @(posedge clk);
        #1;

        dir_mode = 1'b1;
        out_ready = 1'b1;
        pot_sel = '0;
        for (int k = 0; k < 6; k++) issue(4'b0001, 1'b1);
        drain();
        dir_mode = 1'b0;
        check("dir_steps", dir_k, 6);

        issue(4'b1110, 1'b1);
        drain();
        issue(4'b1111, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("in_ready_rst_low", int'(in_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check("idle_after_rst", int'(in_ready), 1);
        for (int i = 0; i < N; i++) begin
            pot_sel = 2'(i);
            #1;
            check("pot_after_rst", int'(pot_out), 0);
        end
        for (int k = 0; k < 2 * N; k++) begin
            @(negedge clk);
            check("no_out_after_rst", int'(out_valid), 0);
        end
        @(posedge clk);
        #1;

        rnd_mode = 1'b1;
        for (int k = 0; k < 400; k++) begin
            in_valid = ($urandom % 2) == 1;
            in_bits  = N'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_t e;
                e = model_step(in_bits);
                e.acc = cyc;
                q.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rnd_mode = 1'b0;
        out_ready = 1'b1;
        drain();
        check("sat_seen", int'(sat_n > 0), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
